// File: rtl/clk_step_ctrl_if.sv
// Control/status bundle between the CPU clock-enable scheduler and its users.
// master drives run/step/rate_sel/halt_req; slave (the scheduler) drives the strobe and status.
interface clk_step_ctrl_if;
    logic       run;
    logic       step;
    logic [1:0] rate_sel;
    logic       halt_req;
    logic       cpu_ce;
    logic       tick_led;
    logic [1:0] mode;
    logic       halted;

    modport master (
        output run,
        output step,
        output rate_sel,
        output halt_req,
        input  cpu_ce,
        input  tick_led,
        input  mode,
        input  halted
    );

    modport slave (
        input  run,
        input  step,
        input  rate_sel,
        input  halt_req,
        output cpu_ce,
        output tick_led,
        output mode,
        output halted
    );
endinterface

// File: rtl/clk_step_ctrl.sv
// CPU clock-enable scheduler: decade prescaler plus IDLE/RUN/STEP sequencer driving cpu_ce.
// Optional macro CLK_STEP_SYNC_EN inserts 2-flop synchronizers on run and step.
module clk_step_ctrl #(
    parameter int DIV_BASE = 10,
    parameter int CNT_W    = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    clk_step_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic [1:0]       r_rate;
    logic             r_halted;
    logic             w_halted_next;
    logic             r_led;

    logic [1:0]       w_raw;
    logic [1:0]       w_cond;
    logic [1:0]       r_in;
    logic             r_step_d;

    logic             w_run;
    logic             w_step_rise;
    logic             w_tick;
    logic             w_ce;
    logic             w_rate_load;
    logic             w_halt_set;
    logic [CNT_W-1:0] w_term [4];

    // Terminal count per rate_sel: DIV_BASE^k - 1.
    for (genvar gi = 0; gi < 4; gi++) begin : g_term
        assign w_term[gi] = CNT_W'(DIV_BASE ** gi - 1);
    end

    assign w_raw = {bus.step, bus.run};

`ifdef CLK_STEP_SYNC_EN
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        logic r_meta;
        logic r_sync;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_meta <= 1'b0;
                r_sync <= 1'b0;
            end else begin
                r_meta <= w_raw[gi];
                r_sync <= r_meta;
            end
        end

        assign w_cond[gi] = r_sync;
    end
`else
    assign w_cond = w_raw;
`endif

    // Registered inputs; r_step_d holds the previous step sample for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in     <= 2'b00;
            r_step_d <= 1'b0;
        end else begin
            r_in     <= w_cond;
            r_step_d <= r_in[1];
        end
    end

    assign w_run       = r_in[0];
    assign w_step_rise = r_in[1] & ~r_step_d;

    assign w_tick      = (r_count == w_term[r_rate]);
    assign w_rate_load = (r_state == S_IDLE) || w_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    // Count returns to 0 whenever the next state is IDLE or a period completes.
    always_comb begin
        w_state_next = r_state;
        w_count_next = '0;
        w_ce         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_run && !r_halted) begin
                    w_state_next = S_RUN;
                end else if (w_step_rise) begin
                    w_state_next = S_STEP;
                end
            end
            S_RUN: begin
                w_ce = w_tick;
                if (!w_run || (w_tick && bus.halt_req)) begin
                    w_state_next = S_IDLE;
                end else if (!w_tick) begin
                    w_count_next = r_count + CNT_W'(1);
                end
            end
            S_STEP: begin
                w_ce = w_tick;
                if (w_tick) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_count_next = r_count + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // A halt set on a strobe wins over the run-low clear in the same cycle.
    assign w_halt_set    = w_ce & bus.halt_req;
    assign w_halted_next = w_halt_set | (r_halted & w_run);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rate   <= 2'b00;
            r_halted <= 1'b0;
            r_led    <= 1'b0;
        end else begin
            if (w_rate_load) begin
                r_rate <= bus.rate_sel;
            end
            r_halted <= w_halted_next;
            r_led    <= r_led ^ w_ce;
        end
    end

    assign bus.cpu_ce   = w_ce;
    assign bus.tick_led = r_led;
    assign bus.mode     = r_state;
    assign bus.halted   = r_halted;

endmodule
